key_debounce_array: RTL and testbench
=====================================

# key_debounce_array

Parametrised N-channel push-button front end. It synchronises raw key inputs, debounces each channel with a sampled stability counter, and emits one-cycle press and release pulses. An optional hold-to-repeat feature can be compiled in. It sits between the board buttons and the game control FSM, which consumes the pulses and the priority-encoded key code.

## Interface
- N_KEYS, 4, number of key channels (≥1)
- SAMPLE_DIV, 50000, clk cycles per sample tick (≥1)
- STABLE_SAMPLES, 4, consecutive differing samples needed to accept a level change (≥1)
- REPEAT_DELAY, 50, ticks held before the first repeat pulse (≥1, used only with repeat)
- REPEAT_RATE, 10, ticks between later repeat pulses (≥1, used only with repeat)
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- keys_in  in  N_KEYS  raw asynchronous key levels, 1 = pressed
- key_level  out  N_KEYS  debounced key state
- key_press  out  N_KEYS  one-cycle pulse per accepted press or repeat
- key_release  out  N_KEYS  one-cycle pulse per accepted release
- key_repeat  out  1  high with key_press when the pulse is a repeat
- key_valid  out  1  high in any cycle where key_press is nonzero
- key_code  out  max(1,$clog2(N_KEYS))  index of lowest set key_press bit; 0 when key_valid=0

## Operation
- Each channel passes through a 2-flop synchroniser. Synchroniser flops reset to 0.
- Divider counts 0..SAMPLE_DIV-1 and wraps. A tick occurs in the cycle where the count equals SAMPLE_DIV-1. With SAMPLE_DIV=1, a tick occurs every cycle.
- On each tick, per channel:
  - synced input ≠ key_level: stable counter increments.
  - synced input = key_level: stable counter clears.
  - Stable counter reaches STABLE_SAMPLES: key_level toggles and the counter clears.
- key_level 0→1: key_press bit pulses. key_level 1→0: key_release bit pulses.
- A glitch lasting fewer than STABLE_SAMPLES consecutive samples produces no output.
- Channels are fully independent. Simultaneous acceptances on several channels pulse all of their bits in the same cycle; key_code reports the lowest index.
- Repeat (macro on), per channel:
  - The repeat counter clears on press and counts ticks while key_level=1.
  - At REPEAT_DELAY ticks: key_press pulses with key_repeat=1.
  - After that, a repeat pulse occurs every REPEAT_RATE ticks until release.
  - Release clears the counter.
  - key_repeat=1 when any pulsing channel's pulse is a repeat.
- Counter widths are sized with $clog2 of their maximum count and must never wrap past their limits. The repeat counter saturates at its reload point.

## Timing
- Reset values:
  - key_level, key_press, key_release, key_repeat, key_valid, key_code: all 0.
  - Divider, stable counters and repeat counters: all 0.
- key_level, key_press and key_release update on the clk edge that ends the accepting tick cycle. All three are registered.
- key_valid, key_code and key_repeat are valid in the same cycle as key_press.
- Latency from a clean input edge to the pulse:
  - ≥ 2 + (STABLE_SAMPLES-1)·SAMPLE_DIV + 1 cycles.
  - ≤ 2 + STABLE_SAMPLES·SAMPLE_DIV + 1 cycles.
- Pulses are exactly one clk cycle wide. A given channel never pulses press and release in the same cycle.
- Reset asserted mid-operation:
  - All state clears immediately on the next edge, and no release pulse is emitted.
  - A key still held after reset deasserts is reported as a fresh press once stable.

## Configuration
- KEY_REPEAT_EN defined: repeat counters and repeat pulses are present, as described above.
- KEY_REPEAT_EN undefined:
  - No repeat logic is built.
  - key_press pulses only on 0→1 acceptance, and key_repeat is tied to 0.
  - REPEAT_DELAY and REPEAT_RATE are ignored.

## Test plan
All scenarios use N_KEYS=4, SAMPLE_DIV=4, STABLE_SAMPLES=3, REPEAT_DELAY=5, REPEAT_RATE=2.
- Reset then idle 100 cycles -> all outputs 0 throughout.
- keys_in[2] rises and holds -> exactly one key_press[2] pulse, key_code=2, key_valid=1, within 10–15 cycles of the edge. key_level[2]=1 afterwards.
- keys_in[1] high for 2 samples (8 cycles) then low -> no pulses, key_level[1] stays 0.
- keys_in[0] and keys_in[3] rise in the same cycle -> key_press=4'b1001 in one cycle, key_code=0.
- keys_in[1] held for 60 ticks with KEY_REPEAT_EN -> first repeat pulse 5 ticks after the press pulse, then one every 2 ticks, each with key_repeat=1. Releasing gives one key_release[1] pulse. Without the macro: a single press pulse only.
- Reset pulsed while keys_in[3] is held -> no release pulse, outputs clear, then a new key_press[3] appears after re-debounce.

Source files
------------

// File: rtl/key_debounce_array.sv
// N-channel key front end: 2-flop synchroniser, sampled stability debounce, press/release pulses.
// Optional hold-to-repeat is compiled in when KEY_REPEAT_EN is defined.
module key_debounce_array #(
  parameter int unsigned N_KEYS         = 4,
  parameter int unsigned SAMPLE_DIV     = 50000,
  parameter int unsigned STABLE_SAMPLES = 4,
  parameter int unsigned REPEAT_DELAY   = 50,
  parameter int unsigned REPEAT_RATE    = 10,
  localparam int unsigned KCW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] keys_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              key_repeat,
  output logic              key_valid,
  output logic [KCW-1:0]    key_code
);

  localparam int unsigned DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned SW = $clog2(STABLE_SAMPLES + 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(SAMPLE_DIV - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_SAMPLES - 1);

  logic [N_KEYS-1:0]         sync1, sync2;
  logic [DW-1:0]             div_cnt;
  logic                      tick;
  logic [N_KEYS-1:0][SW-1:0] stable_cnt, stable_nxt;
  logic [N_KEYS-1:0]         accept, rise, fall, rep_hit;
  logic                      found;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keys_in;
      sync2 <= sync1;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Counter holds 0..STABLE_SAMPLES-1; the sample that would reach the limit accepts instead.
  always_comb begin
    accept     = '0;
    stable_nxt = stable_cnt;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      if (tick) begin
        if (sync2[i] != key_level[i]) begin
          if (stable_cnt[i] == STABLE_LAST) begin
            accept[i]     = 1'b1;
            stable_nxt[i] = '0;
          end else begin
            stable_nxt[i] = stable_cnt[i] + 1'b1;
          end
        end else begin
          stable_nxt[i] = '0;
        end
      end
    end
  end

  assign rise = accept & ~key_level;
  assign fall = accept & key_level;

  always_ff @(posedge clk) begin
    if (!reset) stable_cnt <= '0;
    else        stable_cnt <= stable_nxt;
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [N_KEYS-1:0][RW-1:0] rpt_cnt;
  logic [N_KEYS-1:0]         rpt_phase;

  // Phase 0 waits REPEAT_DELAY ticks, phase 1 reloads every REPEAT_RATE ticks.
  always_comb begin
    rep_hit = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      rep_hit[i] = tick && key_level[i] && !fall[i] &&
                   (rpt_cnt[i] == (rpt_phase[i] ? RATE_LAST : DELAY_LAST));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rpt_cnt   <= '0;
      rpt_phase <= '0;
    end else begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (!key_level[i] || fall[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_phase[i] <= 1'b0;
        end else if (rep_hit[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_phase[i] <= 1'b1;
        end else if (tick) begin
          rpt_cnt[i]   <= rpt_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};

  always_comb begin
    rep_hit = '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_repeat  <= 1'b0;
    end else begin
      key_level   <= key_level ^ accept;
      key_press   <= rise | rep_hit;
      key_release <= fall;
      key_repeat  <= |rep_hit;
    end
  end

  assign key_valid = |key_press;

  always_comb begin
    key_code = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      if (key_press[i] && !found) begin
        key_code = KCW'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Self-checking bench for key_debounce_array against a tick/sample-count reference model.
module tb_key_debounce_array;
  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int STB = 3;
  localparam int RD  = 5;
  localparam int RR  = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] keys_in;
  logic [N-1:0] key_level, key_press, key_release;
  logic         key_repeat, key_valid;
  logic [1:0]   key_code;
  logic [15:0]  dut_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_debounce_array #(
    .N_KEYS(N), .SAMPLE_DIV(DIV), .STABLE_SAMPLES(STB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .reset(reset), .keys_in(keys_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_repeat(key_repeat), .key_valid(key_valid), .key_code(key_code)
  );

  assign dut_vec = {key_level, key_press, key_release, key_repeat, key_valid, key_code};

  // Reference model: cycles since reset, 2-edge input delay, run length of differing samples,
  // ticks held since press.
  int           m_cyc;
  logic [N-1:0] m_q[$];
  logic [N-1:0] m_level, m_press, m_release;
  logic         m_repeat;
  int           m_run[N];
  int           m_held[N];

  function automatic logic [15:0] exp_vec();
    logic [1:0] c;
    c = '0;
    for (int i = N - 1; i >= 0; i--) if (m_press[i]) c = 2'(i);
    return {m_level, m_press, m_release, m_repeat, |m_press, c};
  endfunction

  task automatic step(input logic [N-1:0] k, input logic r);
    logic [N-1:0] used;
    bit           tk, acc;
    @(negedge clk);
    keys_in = k;
    reset   = r;
    @(posedge clk);
    m_press = '0; m_release = '0; m_repeat = 1'b0;
    if (!r) begin
      m_cyc = 0;
      m_q = {4'b0000, 4'b0000};
      m_level = '0;
      foreach (m_run[i]) begin m_run[i] = 0; m_held[i] = 0; end
    end else begin
      tk = (m_cyc % DIV) == DIV - 1;
      m_cyc++;
      used = m_q.pop_front();
      m_q.push_back(k);
      if (tk) begin
        for (int i = 0; i < N; i++) begin
          acc = 0;
          if (used[i] != m_level[i]) begin
            m_run[i]++;
            if (m_run[i] == STB) begin
              acc = 1;
              m_run[i] = 0;
              m_level[i] = ~m_level[i];
              if (m_level[i]) begin m_press[i] = 1'b1; m_held[i] = 0; end
              else m_release[i] = 1'b1;
            end
          end else begin
            m_run[i] = 0;
          end
`ifdef KEY_REPEAT_EN
          if (!acc && m_level[i]) begin
            m_held[i]++;
            if (m_held[i] >= RD && (m_held[i] - RD) % RR == 0) begin
              m_press[i] = 1'b1;
              m_repeat = 1'b1;
            end
          end
`endif
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int j = 0; j < 3; j++) begin
      step('0, 1'b0);
      checks++;
      if (dut_vec !== 16'h0) begin
        errors++; $display("FAIL reset_state: dut=%h want=%h", dut_vec, 16'h0);
      end
    end
    for (int j = 0; j < 100; j++) begin
      step('0, 1'b1);
      checks++;
      if (dut_vec !== 16'h0 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL idle cyc%0d: dut=%h want=%h", j, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_single_press();
    int n = 0, at = -1;
    for (int j = 1; j <= 25; j++) begin
      step(4'b0100, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL single_model cyc%0d: dut=%h want=%h", j, dut_vec, exp_vec());
      end
      if (key_press[2]) begin
        n++; at = j;
        checks++;
        if (key_code !== 2'd2 || key_valid !== 1'b1) begin
          errors++; $display("FAIL single_code: code=%0d valid=%b want 2/1", key_code, key_valid);
        end
      end
    end
    checks++;
    if (n != 1 || at < 10 || at > 15) begin
      errors++; $display("FAIL single_press: pulses=%0d at=%0d want 1 in 10..15", n, at);
    end
    checks++;
    if (key_level[2] !== 1'b1) begin
      errors++; $display("FAIL single_level: level=%b want 1", key_level[2]);
    end
  endtask

  task automatic test_glitch();
    int n = 0;
    for (int j = 0; j < 38; j++) begin
      step((j < 8) ? 4'b0110 : 4'b0100, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL glitch_model cyc%0d: dut=%h want=%h", j, dut_vec, exp_vec());
      end
      if (key_press[1] || key_release[1] || key_level[1]) n++;
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL glitch: ch1 activity cycles=%0d want 0", n);
    end
  endtask

  task automatic test_simultaneous();
    int n = 0;
    for (int j = 0; j < 40; j++) begin
      step('0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL simul_idle cyc%0d: dut=%h want=%h", j, dut_vec, exp_vec());
      end
    end
    for (int j = 0; j < 25; j++) begin
      step(4'b1001, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL simul_model cyc%0d: dut=%h want=%h", j, dut_vec, exp_vec());
      end
      if (key_press != '0) begin
        n++;
        checks++;
        if (key_press !== 4'b1001 || key_code !== 2'd0) begin
          errors++; $display("FAIL simul_press: press=%b code=%0d want 1001/0", key_press, key_code);
        end
      end
    end
    checks++;
    if (n != 1) begin
      errors++; $display("FAIL simul_count: pulses=%0d want 1", n);
    end
  endtask

  task automatic test_repeat();
    int at[$];
    logic rp[$];
    int rel = 0;
    for (int j = 0; j < 40; j++) begin
      step('0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rpt_idle cyc%0d: dut=%h want=%h", j, dut_vec, exp_vec());
      end
    end
    for (int j = 0; j < 260; j++) begin
      step(4'b0010, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rpt_model cyc%0d: dut=%h want=%h", j, dut_vec, exp_vec());
      end
      if (key_press[1]) begin at.push_back(j); rp.push_back(key_repeat); end
    end
`ifdef KEY_REPEAT_EN
    checks++;
    if (at.size() < 3 || rp[0] !== 1'b0 || at[1] - at[0] != RD * DIV) begin
      errors++; $display("FAIL rpt_first: pulses=%0d gap=%0d want >=3 gap %0d",
                         at.size(), (at.size() > 1) ? at[1] - at[0] : -1, RD * DIV);
    end
    for (int i = 1; i < at.size(); i++) begin
      checks++;
      if (rp[i] !== 1'b1 || (i > 1 && at[i] - at[i-1] != RR * DIV)) begin
        errors++; $display("FAIL rpt_rate #%0d: repeat=%b gap=%0d want 1/%0d",
                           i, rp[i], at[i] - at[i-1], RR * DIV);
      end
    end
`else
    checks++;
    if (at.size() != 1 || rp[0] !== 1'b0) begin
      errors++; $display("FAIL rpt_off: pulses=%0d want 1", at.size());
    end
`endif
    for (int j = 0; j < 40; j++) begin
      step('0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rpt_rel cyc%0d: dut=%h want=%h", j, dut_vec, exp_vec());
      end
      if (key_release[1]) rel++;
    end
    checks++;
    if (rel != 1) begin
      errors++; $display("FAIL rpt_release: pulses=%0d want 1", rel);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0, rel = 0;
    for (int j = 0; j < 25; j++) begin
      step(4'b1000, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rmid_pre cyc%0d: dut=%h want=%h", j, dut_vec, exp_vec());
      end
    end
    for (int j = 0; j < 3; j++) begin
      step(4'b1000, 1'b0);
      checks++;
      if (dut_vec !== 16'h0) begin
        errors++; $display("FAIL rmid_clear cyc%0d: dut=%h want=0", j, dut_vec);
      end
    end
    for (int j = 0; j < 25; j++) begin
      step(4'b1000, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rmid_post cyc%0d: dut=%h want=%h", j, dut_vec, exp_vec());
      end
      if (key_press[3]) n++;
      if (key_release[3]) rel++;
    end
    checks++;
    if (n != 1 || rel != 0 || key_level[3] !== 1'b1) begin
      errors++; $display("FAIL rmid_repress: press=%0d release=%0d level=%b want 1/0/1",
                         n, rel, key_level[3]);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] k = '0;
    logic r;
    for (int j = 0; j < 2000; j++) begin
      if ($urandom_range(5) == 0) k[$urandom_range(N - 1)] ^= 1'b1;
      r = ($urandom_range(399) != 0);
      step(k, r);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc%0d: dut=%h want=%h", j, dut_vec, exp_vec());
      end
      checks++;
      if ((key_press & key_release) !== '0) begin
        errors++; $display("FAIL random_overlap cyc%0d: press=%b release=%b", j, key_press, key_release);
      end
    end
  endtask

  initial begin
    reset   = 1'b0;
    keys_in = '0;
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_repeat();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
